scan_sequencer_3bit: RTL and testbench
======================================

// Module: scan_sequencer_3bit
// PURPOSE
//  Registered 3-bit code sequencer that drives the x,y,z select inputs of the
//  3-to-8 decoder (x = MSB, z = LSB), sitting directly upstream of it.
//  Steps the code up or down through 0..last, holding each code for a
//  programmable dwell time. Supports synchronous load and wrap signalling.
//  Typical use: scanning eight one-hot enables or channels.
// PARAMETERS
//  DWELL_W   4   width of dwell input/counter; max hold = 2**DWELL_W cycles
// PORTS
//  clk       in   1        single clock, rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  en        in   1        1 = run the scan, 0 = freeze code
//  dir       in   1        1 = count up, 0 = count down (sampled at each step)
//  load      in   1        synchronous load of load_val (highest priority)
//  load_val  in   3        code loaded when load=1
//  dwell     in   DWELL_W  hold cycles per code minus 1 (0 = step every cycle)
//  last      in   3        inclusive upper code of the scan range
//  x,y,z     out  1 each   registered code {x,y,z}, to decoder select
//  wrap      out  1        1-cycle pulse, high while the wrapped code is shown
//  active    out  1        1 while FSM is in RUN
// BEHAVIOUR
//  Reset (rst_n=0, async): code=3'b000, dwell_cnt=0, wrap=0, state=IDLE, active=0.
//  FSM states and transitions:
//   - IDLE: code held, dwell_cnt=0. On an edge with en=1: state->RUN, dwell_cnt=0.
//   - RUN, per edge:
//     * en=0: state->IDLE, dwell_cnt=0, code frozen.
//     * else if dwell_cnt==dwell: step the code, dwell_cnt=0.
//     * else: dwell_cnt++.
//  First step: dwell+1 edges after entering RUN. Each code is then held
//   dwell+1 cycles.
//  Step, up (dir=1): if code>=last then code=0 and wrap=1, else code+1.
//  Step, down (dir=0): if code==0 or code>last then code=last and wrap=1,
//   else code-1.
//  wrap is registered. It is high for exactly the first cycle of the wrapped
//   code and 0 on all other cycles.
//  load=1 (either state) overrides stepping on that edge:
//   - code=load_val, dwell_cnt=0, wrap=0.
//   - state follows the en rule above.
//  load_val>last is allowed. The next up step wraps to 0; the next down step
//   goes to last.
//  last=0: code stays 0. Every step asserts wrap.
//  dir, dwell and last may change at any time. They take effect at the next
//   compare or step; no glitch on x,y,z.
//  No combinational path from any input to x,y,z, wrap or active.
//   Output latency is 1 edge.
//  Mid-operation reset: outputs are forced to their reset values
//   asynchronously. Operation resumes from IDLE after rst_n deassertion.
// STRUCTURE
//  Package scan_seq_pkg: CODE_W=3; state enum {IDLE, RUN}; CODE_MAX=3'd7.
//  Sub-module dwell_timer (DWELL_W): counter, clear, compare -> step_pulse.
//  Top level holds the FSM, code register, wrap logic and output registers.
// TESTING
//  1. Reset: rst_n=0 mid-RUN -> x,y,z=000, wrap=0, active=0 immediately,
//     without waiting for clk.
//  2. Up scan: en=1, dir=1, dwell=0, last=7 -> codes 1,2,..,7,0.
//     wrap=1 only on the cycle code=0. Period 8 cycles.
//  3. Dwell hold: dwell=2, last=3, up -> each code held 3 cycles,
//     sequence 0,1,2,3,0, wrap on 0.
//  4. Down with load: load=1, load_val=5, last=3, dir=0 -> code 5, then 3
//     with wrap=1, then 2,1,0, then 3 with wrap=1.
//  5. Freeze/resume: en=0 while code=4 -> code stays 4, active=0.
//     en=1 -> code 5 after dwell+1 edges.
//  6. Load vs step collision: load=1 on a step edge -> code=load_val, wrap=0,
//     dwell restarts from 0.

Source files
------------

// File: rtl/scan_sequencer_3bit_pkg.sv
// Shared types and step rule for the 3-bit scan sequencer.
// The step function holds the up/down wrap rules in one place.
package scan_seq_pkg;

  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_MAX = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              wrap;
  } step_t;

  function automatic step_t next_code(input logic [CODE_W-1:0] code,
                                      input logic [CODE_W-1:0] last,
                                      input logic              dir);
    step_t r;
    r.wrap = 1'b0;
    if (dir) begin
      if (code >= last || code == CODE_MAX) begin
        r.code = '0;
        r.wrap = 1'b1;
      end else begin
        r.code = code + 1'b1;
      end
    end else begin
      // codes above last (after a load) re-enter the range at last
      if (code == '0 || code > last) begin
        r.code = last;
        r.wrap = 1'b1;
      end else begin
        r.code = code - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_sequencer_3bit_if.sv
// Control and code bus between a scan controller and the sequencer.
interface scan_sequencer_3bit_if #(parameter int DWELL_W = 4) ();
  import scan_seq_pkg::*;

  logic               en;
  logic               dir;
  logic               load;
  logic [CODE_W-1:0]  load_val;
  logic [DWELL_W-1:0] dwell;
  logic [CODE_W-1:0]  last;
  logic               x;
  logic               y;
  logic               z;
  logic               wrap;
  logic               active;

  modport master (
    output en, dir, load, load_val, dwell, last,
    input  x, y, z, wrap, active
  );

  modport slave (
    input  en, dir, load, load_val, dwell, last,
    output x, y, z, wrap, active
  );
endinterface

// File: rtl/scan_sequencer_3bit_dwell_timer.sv
// Dwell counter: counts held cycles and flags the edge on which the code steps.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step_pulse
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               hit;

  always_comb begin
    hit        = (cnt_q == dwell);
    step_pulse = run && hit && !clr;
    cnt_d      = (clr || !run || hit) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_sequencer_3bit.sv
// Registered 3-bit code sequencer driving decoder selects {x,y,z}, with
// programmable dwell, synchronous load and a one-cycle wrap pulse.
module scan_sequencer_3bit
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scan_sequencer_3bit_if.slave bus
);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              wrap_q, wrap_d;
  logic              active;
  logic              run;
  logic              step;
  step_t             nxt;

  assign run = (state_q == RUN) && bus.en;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (bus.load),
    .run        (run),
    .dwell      (bus.dwell),
    .step_pulse (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Both states share the same rule: en alone decides the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en)  state_d = RUN;
      RUN:     if (!bus.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == RUN);
    nxt    = next_code(code_q, bus.last, bus.dir);
    code_d = code_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      code_d = bus.load_val;
    end else if (step) begin
      code_d = nxt.code;
      wrap_d = nxt.wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      code_q <= code_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.x      = code_q[2];
  assign bus.y      = code_q[1];
  assign bus.z      = code_q[0];
  assign bus.wrap   = wrap_q;
  assign bus.active = active;

endmodule

// File: tb/tb_scan_sequencer_3bit.sv
// Bench for scan_sequencer_3bit: directed scenarios then random stimulus,
// all checked cycle by cycle against a behavioural model of the scan rules.
module tb_scan_sequencer_3bit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  // reference model state
  bit m_run;
  int m_code;
  int m_cnt;
  bit m_wrap;

  always #5 clk = ~clk;

  scan_sequencer_3bit_if #(.DWELL_W(4)) sif ();

  scan_sequencer_3bit #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_code = 0; m_cnt = 0; m_wrap = 0;
  endtask

  // One rising edge of the behavioural model, using the currently driven inputs.
  task automatic model_edge();
    int nc, last, dw;
    bit nw;
    nc = m_code; nw = 0;
    last = int'(sif.last);
    dw = int'(sif.dwell);
    if (sif.load) begin
      nc = int'(sif.load_val);
      m_cnt = 0;
    end else if (m_run && sif.en) begin
      if (m_cnt == dw) begin
        m_cnt = 0;
        if (sif.dir) begin
          if (m_code >= last) begin nc = 0; nw = 1; end
          else nc = m_code + 1;
        end else begin
          if (m_code == 0 || m_code > last) begin nc = last; nw = 1; end
          else nc = m_code - 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_cnt = 0;
    end
    m_run  = sif.en;
    m_code = nc;
    m_wrap = nw;
  endtask

  task automatic compare_all();
    check("code",   {5'b0, sif.x, sif.y, sif.z}, 8'(m_code));
    check("wrap",   {7'b0, sif.wrap},            8'(m_wrap));
    check("active", {7'b0, sif.active},          8'(m_run));
  endtask

  // Inputs are driven around the falling edge; outputs are sampled 1 after the rising edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic logic [7:0] code_now();
    return {5'b0, sif.x, sif.y, sif.z};
  endfunction

  initial begin
    int wraps;
    bit reached;

    rst_n = 1'b0;
    sif.en = 0; sif.dir = 1; sif.load = 0; sif.load_val = '0;
    sif.dwell = '0; sif.last = 3'd7;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_code",   code_now(), 8'd0);
    check("rst_wrap",   {7'b0, sif.wrap}, 8'd0);
    check("rst_active", {7'b0, sif.active}, 8'd0);
    rst_n = 1'b1;
    tick();

    // up scan, dwell 0, full range: two wrap pulses in 16 steps
    sif.en = 1; sif.dir = 1; sif.dwell = 4'd0; sif.last = 3'd7;
    tick();
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (sif.wrap) wraps++;
    end
    check("up_wraps", 8'(wraps), 8'd2);
    check("up_end_code", code_now(), 8'd0);

    // dwell hold, short range
    sif.dwell = 4'd2; sif.last = 3'd3;
    for (int i = 0; i < 15; i++) tick();

    // down with out-of-range load
    sif.dir = 0; sif.dwell = 4'd0; sif.last = 3'd3;
    sif.load = 1; sif.load_val = 3'd5;
    tick();
    check("load_code", code_now(), 8'd5);
    sif.load = 0;
    tick();
    check("down_reenter_code", code_now(), 8'd3);
    check("down_reenter_wrap", {7'b0, sif.wrap}, 8'd1);
    for (int i = 0; i < 5; i++) tick();

    // freeze at 4, then resume
    sif.dir = 1; sif.dwell = 4'd1; sif.last = 3'd7;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      if (m_code == 4) reached = 1;
    end
    check("reach_code4", {7'b0, reached}, 8'd1);
    sif.en = 0;
    tick(); tick();
    check("freeze_code",   code_now(), 8'd4);
    check("freeze_active", {7'b0, sif.active}, 8'd0);
    sif.en = 1;
    tick(); tick();
    check("resume_hold", code_now(), 8'd4);
    tick();
    check("resume_step", code_now(), 8'd5);

    // load on a step edge
    sif.dwell = 4'd2;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_run && m_cnt == 2) reached = 1;
      else tick();
    end
    check("reach_step_edge", {7'b0, reached}, 8'd1);
    sif.load = 1; sif.load_val = 3'd6;
    tick();
    check("collide_code", code_now(), 8'd6);
    check("collide_wrap", {7'b0, sif.wrap}, 8'd0);
    sif.load = 0;
    tick(); tick();
    check("collide_hold", code_now(), 8'd6);
    tick();
    check("collide_step", code_now(), 8'd7);

    // last = 0: every step wraps to 0
    sif.dwell = 4'd0; sif.last = 3'd0;
    for (int i = 0; i < 4; i++) tick();
    check("last0_code", code_now(), 8'd0);
    check("last0_wrap", {7'b0, sif.wrap}, 8'd1);

    // asynchronous reset mid-run
    sif.last = 3'd7;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_code",   code_now(), 8'd0);
    check("async_rst_wrap",   {7'b0, sif.wrap}, 8'd0);
    check("async_rst_active", {7'b0, sif.active}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // random stimulus
    for (int i = 0; i < 600; i++) begin
      sif.en       = ($urandom_range(0, 9) != 0);
      sif.dir      = 1'($urandom_range(0, 1));
      sif.load     = ($urandom_range(0, 19) == 0);
      sif.load_val = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) sif.dwell = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sif.last  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
